// File: rtl/instr_fetch_queue.sv
// Prefetching instruction fetch stage. It issues sequential word fetches to a multi-cycle imem,
// buffers the in-order responses in a FIFO, and hands {instruction, pc} to the core over valid/ready.
module instr_fetch_queue #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_count;
   logic [OW-1:0] r_outstanding;
   logic [OW-1:0] r_drop;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [63:0]   r_mem [DEPTH];

   logic [31:0]   w_redirect_pc;
   logic [CW:0]   w_in_use;
   logic          w_grant;
   logic          w_resp;
   logic          w_push;
   logic          w_pop;
   logic [63:0]   w_head;

   assign w_redirect_pc = redirect_pc & ~32'h3;

   // In-flight requests count against FIFO space so that every response has a slot waiting for it.
   assign w_in_use = {1'b0, r_count} + (CW+1)'(r_outstanding);

   assign imem_req  = reset & ~redirect
                    & (w_in_use < (CW+1)'(DEPTH))
                    & (r_outstanding < OW'(MAX_OUTSTANDING));
   assign imem_addr = r_fetch_pc;

   assign w_grant = imem_req & imem_gnt;
   assign w_resp  = imem_rvalid & (r_outstanding != '0);
   assign w_push  = w_resp & (r_drop == '0) & ~redirect;
   assign w_pop   = instr_valid & instr_ready;

   assign w_head      = r_mem[r_rd_ptr];
   assign instr_valid = (r_count != '0);
   assign instruction = instr_valid ? w_head[63:32] : 32'h0;
   assign instr_pc    = instr_valid ? w_head[31:0]  : 32'h0;

   // NOTE: sequential state uses <= only, so every process sees the pre-edge values of its peers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else if (redirect) begin
         // Everything still in flight after this edge belongs to the old stream.
         r_fetch_pc    <= w_redirect_pc;
         r_resp_pc     <= w_redirect_pc;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_outstanding <= r_outstanding - OW'(w_resp);
         r_drop        <= r_outstanding - OW'(w_resp);
      end else begin
         if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
         r_outstanding <= r_outstanding + OW'(w_grant) - OW'(w_resp);
         if (w_resp && (r_drop != '0)) r_drop <= r_drop - OW'(1);
         if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + PW'(1);
            r_resp_pc <= r_resp_pc + 32'd4;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // NOTE: the storage array has no reset; empty-state outputs are masked by instr_valid instead.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {imem_rdata, r_resp_pc};
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a queue-based imem model with 1-cycle response latency
// that can be held off, plus a linear sequence of checks on the fetch and core-side ports.
module tb_instr_fetch_queue;

   logic        clock;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_ready;

   logic        resp_en;
   int          grant_cnt;
   logic [31:0] pend_q[$];
   int          n_cmp;
   int          n_err;

   instr_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   // imem model: grants are queued, the head is returned one cycle later unless held by resp_en.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_q.delete();
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end else begin
         if (imem_rvalid) void'(pend_q.pop_front());
         if (imem_req && imem_gnt) begin
            pend_q.push_back(imem_addr);
            grant_cnt++;
         end
         #1;
         imem_rvalid = resp_en && (pend_q.size() > 0);
         imem_rdata  = imem_rvalid ? word(pend_q[0]) : 32'h0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_req"},   {31'h0, imem_req},    32'h0);
      check({tag, "_addr"},  imem_addr,            32'h0);
      check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
      check({tag, "_instr"}, instruction,          32'h0);
      check({tag, "_pc"},    instr_pc,             32'h0);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
      check({tag, "_pc"},    instr_pc,             pc);
      check({tag, "_instr"}, instruction,          word(pc));
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!instr_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_timeout"}, {31'h0, instr_valid}, 32'h1);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; grant_cnt = 0;
      reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b0; instr_ready = 1'b0; resp_en = 1'b0;
      repeat (2) @(negedge clock);
      check_empty("rst");

      // Free-running fetch with 1-cycle latency.
      imem_gnt = 1'b1; instr_ready = 1'b1; resp_en = 1'b1; reset = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         check("t1_addr", imem_addr, 32'(4 * k));
         if (k >= 2) check_head("t1", 32'(4 * (k - 2)));
      end

      // Core stalls: FIFO fills to DEPTH, then drains in order.
      reset = 1'b0; instr_ready = 1'b0;
      @(negedge clock);
      grant_cnt = 0;
      reset = 1'b1;
      repeat (10) @(negedge clock);
      check("t2_grants", 32'(grant_cnt), 32'd4);
      check("t2_req", {31'h0, imem_req}, 32'h0);
      check("t2_addr", imem_addr, 32'h10);
      check_head("t2_hold", 32'h0);
      instr_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         if (i == 1) begin
            check("t2_resume_req", {31'h0, imem_req}, 32'h1);
            check("t2_resume_addr", imem_addr, 32'h10);
         end
         check_head("t2_drain", 32'(4 * i));
      end

      // Redirect with two requests in flight: both responses are dropped.
      reset = 1'b0; imem_gnt = 1'b0; resp_en = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      redirect = 1'b1; redirect_pc = 32'h20;
      @(negedge clock);
      check("t3_rebase_addr", imem_addr, 32'h20);
      check("t3_redir_req", {31'h0, imem_req}, 32'h0);
      redirect = 1'b0; imem_gnt = 1'b1;
      repeat (2) @(negedge clock);
      check("t3_credit_req", {31'h0, imem_req}, 32'h0);
      check("t3_credit_addr", imem_addr, 32'h28);
      redirect = 1'b1; redirect_pc = 32'h103;
      @(negedge clock);
      check("t3_new_addr", imem_addr, 32'h100);
      check("t3_flushed", {31'h0, instr_valid}, 32'h0);
      redirect = 1'b0; resp_en = 1'b1;
      wait_valid("t3");
      check_head("t3_first", 32'h100);
      @(negedge clock);
      check_head("t3_second", 32'h104);

      // Redirect coinciding with a pop and an arriving response.
      check("t4_pre_rvalid", {31'h0, imem_rvalid}, 32'h1);
      redirect = 1'b1; redirect_pc = 32'h200;
      @(negedge clock);
      check("t4_empty_valid", {31'h0, instr_valid}, 32'h0);
      check("t4_empty_instr", instruction, 32'h0);
      check("t4_empty_pc", instr_pc, 32'h0);
      check("t4_addr", imem_addr, 32'h200);
      redirect = 1'b0;
      wait_valid("t4");
      check_head("t4_first", 32'h200);
      @(negedge clock);
      check_head("t4_second", 32'h204);

      // Address wrap at the top of the address space.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      @(negedge clock);
      redirect = 1'b0;
      wait_valid("t5");
      check_head("t5_a", 32'hFFFF_FFF8);
      @(negedge clock);
      check_head("t5_b", 32'hFFFF_FFFC);
      @(negedge clock);
      check_head("t5_c", 32'h0000_0000);

      // Asynchronous reset with two requests outstanding.
      instr_ready = 1'b0; resp_en = 1'b0;
      repeat (3) @(negedge clock);
      check("t6_pre_valid", {31'h0, instr_valid}, 32'h1);
      check("t6_pre_req", {31'h0, imem_req}, 32'h0);
      #2 reset = 1'b0;
      #1 check_empty("t6_async");
      @(negedge clock);
      instr_ready = 1'b1; resp_en = 1'b1; reset = 1'b1;
      #1;
      check("t6_release_req", {31'h0, imem_req}, 32'h1);
      check("t6_release_addr", imem_addr, 32'h0);
      @(negedge clock);
      check("t6_next_addr", imem_addr, 32'h4);
      wait_valid("t6");
      check_head("t6_first", 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
